// File: rtl/life_grid_ctrl.sv
// Sequencer for the life_cell scan chain: serial seed load, generation stepping, and a
// recirculating non-destructive readout. Optional generation counter: define GEN_COUNT_EN.
module life_grid_ctrl #(
  parameter int CELLS   = 64,
  parameter int GEN_DIV = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        step,
  input  logic        run,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  input  logic        chain_out,
  output logic        enb,
  output logic        scan,
  output logic        scan_val,
  output logic        out_valid,
  output logic        out_bit,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] gen_count
);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, READ, WAIT} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CELLS - 1);
  localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(GEN_DIV - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] div_cnt;
  logic             in_acc;
  logic             out_acc;

  assign in_acc  = (state == LOAD) && in_valid;
  assign out_acc = (state == READ) && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_start)  state_next = LOAD;
        else if (step)   state_next = STEP;
        else if (run)    state_next = WAIT;
      end
      LOAD: if (in_acc && bit_cnt == LAST_BIT) state_next = IDLE;
      STEP: state_next = READ;
      READ: if (out_acc && bit_cnt == LAST_BIT) state_next = run ? WAIT : IDLE;
      WAIT: begin
        if (!run)                    state_next = IDLE;
        else if (div_cnt == LAST_DIV) state_next = STEP;
      end
      default: state_next = IDLE;
    endcase
  end

  // bit_cnt is zeroed in the states that precede LOAD and READ, so each frame starts at 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      if (state == IDLE || state == STEP) bit_cnt <= '0;
      else if (in_acc || out_acc)         bit_cnt <= bit_cnt + CNT_W'(1);
      if (state == WAIT) div_cnt <= div_cnt + CNT_W'(1);
      else               div_cnt <= '0;
    end
  end

  assign out_bit = chain_out;

  always_comb begin
    enb       = 1'b0;
    scan      = 1'b0;
    scan_val  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        scan     = in_valid;
        scan_val = in_bit;
      end
      STEP: enb = 1'b1;
      READ: begin
        out_valid = 1'b1;
        out_last  = (bit_cnt == LAST_BIT);
        scan      = out_ready;
        scan_val  = chain_out;
      end
      default: ;
    endcase
  end

`ifdef GEN_COUNT_EN
  logic [15:0] gen_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)                          gen_cnt_q <= 16'h0000;
    else if (state == IDLE && load_start) gen_cnt_q <= 16'h0000;
    else if (state == STEP)               gen_cnt_q <= gen_cnt_q + 16'd1;
  end

  assign gen_count = gen_cnt_q;
`else
  assign gen_count = 16'h0000;
`endif

endmodule

// File: tb/tb_life_grid_ctrl.sv
// Directed bench for life_grid_ctrl with a 4-cell behavioural chain whose generation rule
// is new[i] = c[i] ^ c[i+1] (ring); expected readouts are hand-computed from that rule.
module tb_life_grid_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start, step, run, in_valid, in_bit, out_ready;
  logic        in_ready, chain_out, enb, scan, scan_val;
  logic        out_valid, out_bit, out_last, busy;
  logic [15:0] gen_count;

  logic [3:0]  c = 4'b0000;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          enb_cnt = 0;
  int          scan_cnt = 0;
  int          excl_err = 0;
  int          t1, t2, t3;

`ifdef GEN_COUNT_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  always #5 clk = ~clk;

  life_grid_ctrl #(.CELLS(4), .GEN_DIV(3), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .step(step), .run(run),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .chain_out(chain_out),
    .enb(enb), .scan(scan), .scan_val(scan_val), .out_valid(out_valid),
    .out_bit(out_bit), .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .gen_count(gen_count)
  );

  assign chain_out = c[3];

  // Behavioural cell array: c[0] is fed by scan_val, c[3] drives chain_out
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (enb) enb_cnt <= enb_cnt + 1;
    if (scan) scan_cnt <= scan_cnt + 1;
    if (enb && scan) excl_err <= excl_err + 1;
    if (enb)       c <= {c[3] ^ c[0], c[2] ^ c[3], c[1] ^ c[2], c[0] ^ c[1]};
    else if (scan) c <= {c[2:0], scan_val};
  end

  function automatic int gc(input int n);
    return GC ? n : 0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ls, input logic st, input logic rn,
                                input logic iv, input logic ib, input logic ordy);
    load_start = ls;
    step       = st;
    run        = rn;
    in_valid   = iv;
    in_bit     = ib;
    out_ready  = ordy;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One readout frame; pat[k] is out_ready in the k-th READ cycle, run drops at cycle drop_at
  task automatic read_frame(input string tag, input logic [3:0] exp_bits,
                            input logic [6:0] pat, input int n, input int drop_at);
    int idx;
    int scan0;
    idx   = 0;
    scan0 = scan_cnt;
    for (int k = 0; k < n; k++) begin
      out_ready = pat[k];
      if (k == drop_at) run = 1'b0;
      #1;
      check_output({tag, "_valid"}, out_valid, 1'b1);
      check_output({tag, "_bit"}, out_bit, exp_bits[3 - idx]);
      check_output({tag, "_last"}, out_last, idx == 3);
      check_output({tag, "_scan"}, scan, pat[k]);
      next_cycle();
      if (pat[k]) idx++;
    end
    check_output({tag, "_shifts"}, scan_cnt - scan0, 4);
  endtask

  task automatic wait_enb(output int at_cyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      if (enb) got = 1'b1;
      else     next_cycle();
    end
    at_cyc = cyc;
    check_output("enb_seen", got, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    #1;
    check_output("rst_enb", enb, 1'b0);
    check_output("rst_scan", scan, 1'b0);
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_last", out_last, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_gen_count", gen_count, 16'h0000);
    reset = 1'b1;
    next_cycle();

    $display("[TB] load 1,0,1,1 with a two-cycle gap");
    scan_cnt = 0;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 1, 1, 0);
    check_output("load_in_ready", in_ready, 1'b1);
    check_output("load_scan", scan, 1'b1);
    check_output("load_busy", busy, 1'b1);
    next_cycle();
    apply_stimulus(0, 0, 0, 1, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 1, 0);
    check_output("gap_scan", scan, 1'b0);
    check_output("gap_in_ready", in_ready, 1'b1);
    next_cycle();
    next_cycle();
    apply_stimulus(0, 0, 0, 1, 1, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 1, 1, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("load_done_busy", busy, 1'b0);
    check_output("load_done_in_ready", in_ready, 1'b0);
    check_output("load_chain", c, 4'b1011);
    check_output("load_scan_cycles", scan_cnt, 4);

    $display("[TB] step and read");
    apply_stimulus(0, 1, 0, 0, 0, 1);
    check_output("pre_step_enb", enb, 1'b0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_output("step_enb", enb, 1'b1);
    check_output("step_scan", scan, 1'b0);
    check_output("step_out_valid", out_valid, 1'b0);
    next_cycle();
    check_output("read1_enb", enb, 1'b0);
    check_output("read1_gen", gen_count, gc(1));
    read_frame("rd1", 4'b0110, 7'b0001111, 4, -1);
    #1;
    check_output("rd1_busy", busy, 1'b0);
    check_output("rd1_out_valid", out_valid, 1'b0);
    check_output("rd1_chain", c, 4'b0110);
    check_output("rd1_enb_cnt", enb_cnt, 1);

    $display("[TB] readout backpressure");
    apply_stimulus(0, 1, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    next_cycle();
    check_output("bp_gen", gen_count, gc(2));
    read_frame("bp", 4'b0101, 7'b1011001, 7, -1);
    #1;
    check_output("bp_busy", busy, 1'b0);
    check_output("bp_chain", c, 4'b0101);

    $display("[TB] run mode");
    apply_stimulus(0, 0, 1, 0, 0, 1);
    next_cycle();
    check_output("run_wait_busy", busy, 1'b1);
    check_output("run_wait_enb", enb, 1'b0);
    wait_enb(t1);
    next_cycle();
    check_output("run1_gen", gen_count, gc(3));
    read_frame("run1", 4'b1111, 7'b1111111, 4, -1);
    wait_enb(t2);
    check_output("run_period_1", t2 - t1, 8);
    next_cycle();
    check_output("run2_gen", gen_count, gc(4));
    read_frame("run2", 4'b0000, 7'b1111111, 4, -1);
    wait_enb(t3);
    check_output("run_period_2", t3 - t2, 8);
    next_cycle();
    check_output("run3_gen", gen_count, gc(5));
    read_frame("run3", 4'b0000, 7'b1111111, 4, 2);
    #1;
    check_output("run_drop_busy", busy, 1'b0);
    repeat (6) next_cycle();
    check_output("run_drop_enb_cnt", enb_cnt, 5);
    check_output("run_drop_idle", busy, 1'b0);

    $display("[TB] priority and reset mid-load");
    apply_stimulus(1, 1, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 1, 1, 0);
    check_output("prio_in_ready", in_ready, 1'b1);
    check_output("prio_enb", enb, 1'b0);
    check_output("prio_gen_clear", gen_count, 16'h0000);
    next_cycle();
    apply_stimulus(0, 0, 0, 1, 0, 0);
    next_cycle();
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b1;
    #1;
    check_output("midload_rst_busy", busy, 1'b0);
    check_output("midload_rst_in_ready", in_ready, 1'b0);
    check_output("midload_rst_gen", gen_count, 16'h0000);
    check_output("prio_enb_cnt", enb_cnt, 5);
    check_output("enb_scan_excl", excl_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_grid_ctrl.md
Name: life_grid_ctrl

Overview:
- Upstream sequencer for the life_cell array. Drives the shared enb, scan and scan_val lines.
- Serially loads a seed pattern into the cell scan chain from a valid/ready bit stream.
- Advances generations on request or on a free-running divider.
- After every generation, streams the grid state out and recirculates it, so readout is non-destructive.

Parameters:
- CELLS, 64: scan chain length (cells in grid), >=2.
- GEN_DIV, 1000000: clk cycles between generations in run mode, >=1.
- CNT_W, 20: width of internal bit/divider counters; must hold max(CELLS, GEN_DIV).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- load_start  in  1  pulse; begin serial load (honoured in IDLE only).
- step  in  1  pulse; advance one generation (honoured in IDLE only).
- run  in  1  level; free-run generations every GEN_DIV cycles.
- in_valid  in  1  seed bit valid.
- in_bit  in  1  seed bit; first accepted bit ends in the last chain cell.
- in_ready  out  1  block accepts a seed bit this cycle.
- chain_out  in  1  alive of the last cell in the scan chain.
- enb  out  1  cell generation enable to all cells.
- scan  out  1  cell scan-shift enable to all cells.
- scan_val  out  1  serial data into the first chain cell.
- out_valid  out  1  readout bit valid.
- out_bit  out  1  readout bit (= chain_out).
- out_last  out  1  marks final bit of a frame.
- out_ready  in  1  consumer accepts the readout bit.
- busy  out  1  state != IDLE.
- gen_count  out  16  generation counter (see Optional Feature).

Behaviour:
- States: IDLE, LOAD, STEP, READ, WAIT. State, counters and gen_count are registered. All other outputs are combinational from state, counters and handshake inputs.
- Reset (reset=0 at a clk edge):
  - state=IDLE, counters=0, gen_count=0.
  - Hence enb=0, scan=0, scan_val=0, in_ready=0, out_valid=0, out_last=0, busy=0.
  - Cell contents are not touched by this block.
- IDLE:
  - Priority load_start > step > run.
  - load_start -> LOAD with bit_cnt=0.
  - step -> STEP.
  - run=1 -> WAIT with div_cnt=0.
- LOAD:
  - in_ready=1.
  - scan = in_valid; scan_val = in_bit.
  - Each accepted bit (in_valid&in_ready) shifts the chain once and increments bit_cnt.
  - The accept with bit_cnt==CELLS-1 -> IDLE.
  - in_valid low stalls: scan=0, chain holds.
- STEP:
  - enb=1 for exactly one cycle; gen_count += 1 (wraps 0xFFFF->0).
  - Next state READ, bit_cnt=0.
- READ:
  - out_valid=1; out_bit=chain_out; out_last=(bit_cnt==CELLS-1).
  - scan=out_ready; scan_val=chain_out (recirculate).
  - Each handshake increments bit_cnt.
  - Last handshake: -> WAIT (div_cnt=0) if run=1, else -> IDLE.
  - After CELLS shifts the grid content equals the pre-READ content.
  - out_ready low stalls with no shift.
- WAIT:
  - div_cnt increments each cycle.
  - div_cnt==GEN_DIV-1 -> STEP.
  - run=0 -> IDLE immediately.
- Latencies:
  - step pulse to enb high: 1 cycle.
  - enb to first out_valid: 1 cycle.
  - Run-mode period: GEN_DIV + 1 + CELLS cycles, with out_ready held high.
- Exclusivity: enb and scan are never high in the same cycle.
- Ignored inputs:
  - load_start, step and run changes outside IDLE/WAIT are ignored.
  - run drop during STEP/READ finishes the frame, then goes to IDLE.
- Reset mid-LOAD or mid-READ:
  - Controller returns to IDLE next cycle.
  - Chain holds a partially shifted pattern; software reloads.

Optional Feature:
- Macro GEN_COUNT_EN.
- Defined: gen_count is a 16-bit register as described; cleared by reset and on entry to LOAD.
- Undefined: counter logic omitted; gen_count tied to 16'h0000.

Test Plan (CELLS=4, GEN_DIV=3, 4-cell model chain of life_cell or behavioural shift register):
- Reset check: hold reset=0 2 cycles -> enb=0, scan=0, in_ready=0, out_valid=0, busy=0, gen_count=0.
- Load with gaps:
  - load_start, then in_bit sequence 1,0,1,1 with in_valid low 2 cycles between bits 2 and 3.
  - Required: exactly 4 cycles with scan=1; chain = 1011 (last cell holds first bit); return to IDLE.
- Step and read:
  - step on loaded grid -> enb high exactly one cycle, gen_count=1.
  - Then 4 readout bits equal to the model's next generation, out_last on 4th.
  - Grid unchanged after readout.
- Readout backpressure: out_ready toggling 1,0,0,1,1,0,1 -> no shift on out_ready=0 cycles, bits not duplicated or lost, scan never high with enb.
- Run mode:
  - run=1 for 3 frames -> enb pulses exactly 3+1+4=8 cycles apart; gen_count increments 1,2,3.
  - Drop run mid-READ -> frame completes, then IDLE.
- Priority and reset:
  - load_start and step same cycle in IDLE -> LOAD entered, no enb.
  - reset=0 mid-LOAD after 2 bits -> IDLE next cycle, in_ready=0.
  - With GEN_COUNT_EN undefined -> gen_count=0 always.
